// File: rtl/rx_dma_pkg.sv
// Shared definitions for the RX DMA primary controller: one-hot state encoding and
// head-pointer validity check.
package rx_dma_pkg;

    typedef enum logic [3:0] {
        StHalted  = 4'b0001,
        StPassive = 4'b0010,
        StActive  = 4'b0100,
        StDead    = 4'b1000
    } rx_pc_state_e;

    // A usable head pointer is word aligned and not null.
    function automatic logic head_ptr_valid(input logic [31:0] ptr);
        return (ptr[1:0] == 2'b00) && (ptr[31:2] != 30'd0);
    endfunction

endpackage

// File: rtl/rx_int_coalesce.sv
// Frame-done interrupt coalescing: counts completed frames and raises one trigger pulse on
// count threshold, idle timeout or end-of-list flush.
module rx_int_coalesce
    import rx_dma_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 8,
    parameter int unsigned TMR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frm_done,
    input  logic                 halt,
    input  logic                 clr,
    input  logic [CNT_WIDTH-1:0] thresh,
    input  logic [TMR_WIDTH-1:0] timeout,
    output logic                 trigger
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [TMR_WIDTH-1:0] timer_q, timer_d;
    logic                 trig_q, trig_d;
    logic [CNT_WIDTH:0]   sum;
    logic [CNT_WIDTH:0]   thr_eff;
    logic                 fire;

    // Extra bit keeps the threshold compare exact even when the counter is saturated.
    assign sum     = {1'b0, cnt_q} + (CNT_WIDTH+1)'(frm_done);
    assign thr_eff = (thresh == '0) ? (CNT_WIDTH+1)'(1) : {1'b0, thresh};

    always_comb begin
        fire    = 1'b0;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        trig_d  = 1'b0;
        if (!clr) begin
            fire = (sum >= thr_eff)
                || ((timeout != '0) && (timer_q == timeout) && (cnt_q != '0))
                || (halt && (sum != '0));
        end
        if (clr || fire) begin
            cnt_d   = '0;
            timer_d = '0;
        end else if (frm_done) begin
            cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_WIDTH'(1);
            timer_d = '0;
        end else if (cnt_q != '0) begin
            timer_d = (timer_q == '1) ? timer_q : timer_q + TMR_WIDTH'(1);
        end
        trig_d = fire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            timer_q <= '0;
            trig_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            trig_q  <= trig_d;
        end
    end

    assign trigger = trig_q;

endmodule

// File: rtl/rx_prim_ctrl.sv
// RX DMA primary controller: head/tail hand-over FSM, status pointer, status flags and
// coalesced frame-done interrupt.
module rx_prim_ctrl
    import rx_dma_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 8,
    parameter int unsigned TMR_WIDTH = 16
) (
    input  logic                 macPIRxClk,
    input  logic                 macPIRxClkHardRst_n,
    input  logic                 rxNewHead,
    input  logic                 rxNewTail,
    input  logic [31:0]          rxHeadPtr,
    input  logic                 rxFrameAvail,
    input  logic                 nxtDescPtrValid,
    input  logic                 trigRxPCHalt_p,
    input  logic                 trigRxPCDead_p,
    input  logic                 rxFrmDone_p,
    input  logic                 updPCStaPtr_p,
    input  logic [31:0]          nxtDescPtr,
    input  logic [CNT_WIDTH-1:0] rxFrmCntThresh,
    input  logic [TMR_WIDTH-1:0] rxTimeout,
    output logic                 pcTrigRxListProc,
    output logic                 rstNewHead_p,
    output logic                 rstNewTail_p,
    output logic [31:0]          pcStatusPtr,
    output logic                 rxNewHeadErr,
    output logic                 rxStartup,
    output logic                 rxEndQ,
    output logic                 rxDMADead,
    output logic                 rxTrigger_p,
    output logic [3:0]           rxDmaPCState
);

    rx_pc_state_e state_q, state_d;
    logic         head_valid;
    logic         in_halted, in_passive, in_active;
    logic [31:0]  ptr_q;
    logic         startup_q, endq_q, dead_q;

    assign head_valid = head_ptr_valid(rxHeadPtr);
    assign in_halted  = (state_q == StHalted);
    assign in_passive = (state_q == StPassive);
    assign in_active  = (state_q == StActive);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StHalted: begin
                if (rxNewTail || (rxNewHead && head_valid)) state_d = StPassive;
                else if (rxNewHead)                         state_d = StDead;
            end
            StPassive: begin
                if (rxNewHead)         state_d = StHalted;
                else if (rxFrameAvail) state_d = StActive;
            end
            StActive: begin
                if (trigRxPCDead_p)                      state_d = StDead;
                else if (trigRxPCHalt_p || rxNewHead)    state_d = StHalted;
                else if (rxFrmDone_p && !rxFrameAvail)   state_d = StPassive;
            end
            StDead:   state_d = StDead;
            default:  state_d = StHalted;
        endcase
    end

    assign rstNewHead_p = in_halted && rxNewHead && head_valid;
    assign rstNewTail_p = rxNewTail && (in_halted || in_passive || (in_active && nxtDescPtrValid));
    assign rxNewHeadErr = rxNewHead && !head_valid;

    always_ff @(posedge macPIRxClk or negedge macPIRxClkHardRst_n) begin
        if (!macPIRxClkHardRst_n) begin
            state_q   <= StHalted;
            ptr_q     <= '0;
            startup_q <= 1'b1;
            endq_q    <= 1'b0;
            dead_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            // A fresh head from software overrides the list processor's pointer update.
            if (rstNewHead_p)       ptr_q <= rxHeadPtr;
            else if (updPCStaPtr_p) ptr_q <= nxtDescPtr;
            if (in_passive || in_active) startup_q <= 1'b0;
            if (trigRxPCHalt_p)                endq_q <= 1'b1;
            else if (in_passive || in_active)  endq_q <= 1'b0;
            dead_q <= (in_active && trigRxPCDead_p) || (in_halted && rxNewHead && !head_valid);
        end
    end

    rx_int_coalesce #(
        .CNT_WIDTH (CNT_WIDTH),
        .TMR_WIDTH (TMR_WIDTH)
    ) u_coalesce (
        .clk      (macPIRxClk),
        .rst_n    (macPIRxClkHardRst_n),
        .frm_done (rxFrmDone_p),
        .halt     (trigRxPCHalt_p),
        .clr      (state_d == StDead),
        .thresh   (rxFrmCntThresh),
        .timeout  (rxTimeout),
        .trigger  (rxTrigger_p)
    );

    assign pcTrigRxListProc = in_active;
    assign pcStatusPtr      = ptr_q;
    assign rxStartup        = startup_q;
    assign rxEndQ           = endq_q;
    assign rxDMADead        = dead_q;
    assign rxDmaPCState     = state_q;

endmodule

// File: tb/tb_rx_prim_ctrl.sv
// Directed scenarios plus randomized traffic for rx_prim_ctrl, checked against a
// transaction-level reference model of the controller.
module tb_rx_prim_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rxNewHead, rxNewTail, rxFrameAvail, nxtDescPtrValid;
    logic        trigRxPCHalt_p, trigRxPCDead_p, rxFrmDone_p, updPCStaPtr_p;
    logic [31:0] rxHeadPtr, nxtDescPtr;
    logic [7:0]  rxFrmCntThresh;
    logic [15:0] rxTimeout;
    logic        pcTrigRxListProc, rstNewHead_p, rstNewTail_p, rxNewHeadErr;
    logic        rxStartup, rxEndQ, rxDMADead, rxTrigger_p;
    logic [31:0] pcStatusPtr;
    logic [3:0]  rxDmaPCState;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode index 0..3 = halted, passive, active, dead
    localparam int M_H = 0, M_P = 1, M_A = 2, M_D = 3;
    int          m_st, m_cnt, m_idle;
    logic [31:0] m_ptr;
    logic        m_startup, m_endq, m_dead, m_trig;

    rx_prim_ctrl #(.CNT_WIDTH(8), .TMR_WIDTH(16)) dut (
        .macPIRxClk          (clk),
        .macPIRxClkHardRst_n (rst_n),
        .rxNewHead           (rxNewHead),
        .rxNewTail           (rxNewTail),
        .rxHeadPtr           (rxHeadPtr),
        .rxFrameAvail        (rxFrameAvail),
        .nxtDescPtrValid     (nxtDescPtrValid),
        .trigRxPCHalt_p      (trigRxPCHalt_p),
        .trigRxPCDead_p      (trigRxPCDead_p),
        .rxFrmDone_p         (rxFrmDone_p),
        .updPCStaPtr_p       (updPCStaPtr_p),
        .nxtDescPtr          (nxtDescPtr),
        .rxFrmCntThresh      (rxFrmCntThresh),
        .rxTimeout           (rxTimeout),
        .pcTrigRxListProc    (pcTrigRxListProc),
        .rstNewHead_p        (rstNewHead_p),
        .rstNewTail_p        (rstNewTail_p),
        .pcStatusPtr         (pcStatusPtr),
        .rxNewHeadErr        (rxNewHeadErr),
        .rxStartup           (rxStartup),
        .rxEndQ              (rxEndQ),
        .rxDMADead           (rxDMADead),
        .rxTrigger_p         (rxTrigger_p),
        .rxDmaPCState        (rxDmaPCState)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulses_off();
        rxNewHead = 0; rxNewTail = 0; trigRxPCHalt_p = 0; trigRxPCDead_p = 0;
        rxFrmDone_p = 0; updPCStaPtr_p = 0;
    endtask

    task automatic check_regs();
        chk("state", {28'd0, rxDmaPCState}, 32'(1) << m_st);
        chk("pcTrig", {31'd0, pcTrigRxListProc}, {31'd0, m_st == M_A});
        chk("ptr", pcStatusPtr, m_ptr);
        chk("startup", {31'd0, rxStartup}, {31'd0, m_startup});
        chk("endq", {31'd0, rxEndQ}, {31'd0, m_endq});
        chk("dead", {31'd0, rxDMADead}, {31'd0, m_dead});
        chk("trig", {31'd0, rxTrigger_p}, {31'd0, m_trig});
    endtask

    task automatic do_reset();
        pulses_off();
        rxFrameAvail = 0; nxtDescPtrValid = 0; rxHeadPtr = 0; nxtDescPtr = 0;
        rst_n = 0;
        @(posedge clk); #1;
        m_st = M_H; m_ptr = 0; m_startup = 1; m_endq = 0; m_dead = 0; m_trig = 0;
        m_cnt = 0; m_idle = 0;
        rst_n = 1;
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic step();
        logic valid, go_dead, fire;
        int   nst, thr, tot;
        #1;
        valid = (rxHeadPtr % 4 == 0) && (rxHeadPtr >= 4);
        chk("headErr", {31'd0, rxNewHeadErr}, {31'd0, rxNewHead && !valid});
        chk("rstHead", {31'd0, rstNewHead_p}, {31'd0, m_st == M_H && rxNewHead && valid});
        chk("rstTail", {31'd0, rstNewTail_p}, {31'd0, rxNewTail &&
            (m_st == M_H || m_st == M_P || (m_st == M_A && nxtDescPtrValid))});
        nst = m_st;
        case (m_st)
            M_H: if (rxNewTail || (rxNewHead && valid)) nst = M_P;
                 else if (rxNewHead) nst = M_D;
            M_P: if (rxNewHead) nst = M_H; else if (rxFrameAvail) nst = M_A;
            M_A: if (trigRxPCDead_p) nst = M_D;
                 else if (trigRxPCHalt_p || rxNewHead) nst = M_H;
                 else if (rxFrmDone_p && !rxFrameAvail) nst = M_P;
            default: nst = M_D;
        endcase
        if (m_st == M_H && rxNewHead && valid) m_ptr = rxHeadPtr;
        else if (updPCStaPtr_p) m_ptr = nxtDescPtr;
        if (m_st == M_P || m_st == M_A) m_startup = 0;
        if (trigRxPCHalt_p) m_endq = 1;
        else if (m_st == M_P || m_st == M_A) m_endq = 0;
        m_dead = (m_st == M_A && trigRxPCDead_p) || (m_st == M_H && rxNewHead && !valid);
        thr = (rxFrmCntThresh == 0) ? 1 : int'(rxFrmCntThresh);
        tot = m_cnt + (rxFrmDone_p ? 1 : 0);
        go_dead = (nst == M_D);
        fire = !go_dead && (tot >= thr || (rxTimeout != 0 && m_cnt != 0 && m_idle == rxTimeout)
                            || (trigRxPCHalt_p && tot != 0));
        if (go_dead || fire) begin
            m_cnt = 0; m_idle = 0;
        end else if (rxFrmDone_p) begin
            m_cnt = (tot > 255) ? 255 : tot; m_idle = 0;
        end else if (m_cnt != 0) begin
            m_idle = (m_idle >= 65535) ? 65535 : m_idle + 1;
        end
        m_trig = fire;
        m_st = nst;
        @(posedge clk); #1;
        check_regs();
    endtask

    task automatic go_active();
        rxHeadPtr = 32'h0000_1000; rxNewHead = 1; step(); rxNewHead = 0;
        rxFrameAvail = 1; step();
    endtask

    initial begin
        int hit_at, hits;
        rxFrmCntThresh = 8; rxTimeout = 0;
        do_reset();

        // T1: reset values, then valid head hand-over
        chk("T1 rst state", {28'd0, rxDmaPCState}, 32'h1);
        chk("T1 rst ptr", pcStatusPtr, 32'h0);
        chk("T1 rst startup", {31'd0, rxStartup}, 32'h1);
        chk("T1 rst endq", {31'd0, rxEndQ}, 32'h0);
        chk("T1 rst trig", {31'd0, rxTrigger_p}, 32'h0);
        rxHeadPtr = 32'h0000_1000; rxNewHead = 1;
        #1 chk("T1 rstHead", {31'd0, rstNewHead_p}, 32'h1);
        step(); rxNewHead = 0;
        chk("T1 passive", {28'd0, rxDmaPCState}, 32'h2);
        chk("T1 ptr", pcStatusPtr, 32'h0000_1000);
        step();
        chk("T1 rstHead off", {31'd0, rstNewHead_p}, 32'h0);
        chk("T1 startup clr", {31'd0, rxStartup}, 32'h0);

        // T3: frame available -> active; last frame done -> passive
        rxFrameAvail = 1; step();
        chk("T3 active", {31'd0, pcTrigRxListProc}, 32'h1);
        rxFrameAvail = 0; rxFrmDone_p = 1; step(); rxFrmDone_p = 0;
        chk("T3 passive", {28'd0, rxDmaPCState}, 32'h2);

        // T2: misaligned head -> error, dead, absorbing
        do_reset();
        rxHeadPtr = 32'h0000_1002; rxNewHead = 1;
        #1 chk("T2 headErr", {31'd0, rxNewHeadErr}, 32'h1);
        step(); rxNewHead = 0;
        chk("T2 dead state", {28'd0, rxDmaPCState}, 32'h8);
        chk("T2 dead pulse", {31'd0, rxDMADead}, 32'h1);
        rxNewTail = 1; rxHeadPtr = 32'h0000_2000; rxNewHead = 1; step(); pulses_off();
        chk("T2 stays dead", {28'd0, rxDmaPCState}, 32'h8);
        chk("T2 pulse ends", {31'd0, rxDMADead}, 32'h0);

        // T4: dead and halt together in active
        do_reset(); go_active();
        rxFrmDone_p = 1; step(); rxFrmDone_p = 0;
        trigRxPCDead_p = 1; trigRxPCHalt_p = 1; step(); pulses_off();
        chk("T4 dead", {28'd0, rxDmaPCState}, 32'h8);
        chk("T4 endq", {31'd0, rxEndQ}, 32'h1);
        chk("T4 no trig", {31'd0, rxTrigger_p}, 32'h0);
        step();
        chk("T4 no late trig", {31'd0, rxTrigger_p}, 32'h0);

        // T5: count threshold
        do_reset(); rxFrmCntThresh = 3; rxTimeout = 0; go_active();
        for (int i = 0; i < 3; i++) begin
            rxFrmDone_p = 1; step();
            chk("T5 trig", {31'd0, rxTrigger_p}, {31'd0, i == 2});
        end
        rxFrmDone_p = 0; step();
        chk("T5 single pulse", {31'd0, rxTrigger_p}, 32'h0);

        // T6: idle timeout, then halt flush
        do_reset(); rxFrmCntThresh = 8; rxTimeout = 20; go_active();
        rxFrmDone_p = 1; step(); rxFrmDone_p = 0;
        hit_at = -1; hits = 0;
        for (int i = 1; i <= 30; i++) begin
            step();
            if (rxTrigger_p === 1'b1) begin
                hits++;
                if (hit_at < 0) hit_at = i;
            end
        end
        chk("T6 timeout at", 32'(hit_at), 32'd21);
        chk("T6 timeout count", 32'(hits), 32'd1);
        rxFrmDone_p = 1; step(); step(); rxFrmDone_p = 0;
        trigRxPCHalt_p = 1; step(); trigRxPCHalt_p = 0;
        chk("T6 flush", {31'd0, rxTrigger_p}, 32'h1);
        chk("T6 halted", {28'd0, rxDmaPCState}, 32'h1);

        // Randomized traffic
        for (int seg = 0; seg < 20; seg++) begin
            do_reset();
            rxFrmCntThresh = 8'($urandom_range(0, 5));
            rxTimeout = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 12));
            for (int i = 0; i < 150; i++) begin
                rxNewHead       = ($urandom_range(0, 30) == 0);
                rxHeadPtr       = ($urandom_range(0, 5) == 0) ? $urandom
                                                              : (($urandom & 32'hFFFF_FFFC) | 32'h4);
                rxNewTail       = ($urandom_range(0, 14) == 0);
                rxFrameAvail    = ($urandom_range(0, 1) == 1);
                nxtDescPtrValid = ($urandom_range(0, 1) == 1);
                trigRxPCHalt_p  = ($urandom_range(0, 39) == 0);
                trigRxPCDead_p  = ($urandom_range(0, 149) == 0);
                rxFrmDone_p     = ($urandom_range(0, 3) == 0);
                updPCStaPtr_p   = ($urandom_range(0, 9) == 0);
                nxtDescPtr      = $urandom;
                step();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
